// File: rtl/rf_scoreboard.sv
// Register file with per-register pending (scoreboard) tracking for an in-order issue pipeline.
// Register 0 is hardwired to zero and is never pending.
module rf_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              RFWr,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic              Alloc,
  input  logic [ADDR_W-1:0] AllocA,
  input  logic              Flush,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   BusyCnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_en, alloc_en, fwd1, fwd2;
  logic cnt_inc, cnt_dec;

  assign wr_en    = RFWr && (A3 != '0);
  assign alloc_en = Alloc && (AllocA != '0);

  // Forwarding is gated by rstn so reset forces reads to zero even with RFWr high.
  assign fwd1 = (BYPASS != 0) && rstn && wr_en && (A3 == A1);
  assign fwd2 = (BYPASS != 0) && rstn && wr_en && (A3 == A2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Depth; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_en) begin
      rf_q[A3] <= WD;
    end
  end

  always_comb begin
    RD1   = '0;
    RD2   = '0;
    Busy1 = 1'b0;
    Busy2 = 1'b0;
    if (A1 != '0) begin
      RD1   = fwd1 ? WD : rf_q[A1];
      Busy1 = busy_q[A1] && !fwd1;
    end
    if (A2 != '0) begin
      RD2   = fwd2 ? WD : rf_q[A2];
      Busy2 = busy_q[A2] && !fwd2;
    end
  end

  // Allocation is applied after the write-back clear so the new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (Flush) begin
      busy_d = '0;
    end else begin
      if (wr_en) begin
        busy_d[A3] = 1'b0;
      end
      if (alloc_en) begin
        busy_d[AllocA] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Incremental popcount: a set only counts on a clear bit, a clear only on a set bit
  // that is not being re-allocated in the same cycle.
  assign cnt_inc = alloc_en && !busy_q[AllocA];
  assign cnt_dec = wr_en && busy_q[A3] && !(alloc_en && (AllocA == A3));

  always_comb begin
    cnt_d = cnt_q;
    if (Flush) begin
      cnt_d = '0;
    end else if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BusyCnt = cnt_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: one forwarding and one non-forwarding instance share stimulus.
module tb_rf_scoreboard;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          RFWr, Alloc, Flush;
  logic [AW-1:0] A1, A2, A3, AllocA;
  logic [DW-1:0] WD;

  logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic          busy1_b, busy2_b, busy1_n, busy2_n;
  logic [AW:0]   cnt_b, cnt_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
    .clk(clk), .rstn(rstn), .RFWr(RFWr), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
    .Alloc(Alloc), .AllocA(AllocA), .Flush(Flush),
    .RD1(rd1_b), .RD2(rd2_b), .Busy1(busy1_b), .Busy2(busy2_b), .BusyCnt(cnt_b)
  );

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nob (
    .clk(clk), .rstn(rstn), .RFWr(RFWr), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
    .Alloc(Alloc), .AllocA(AllocA), .Flush(Flush),
    .RD1(rd1_n), .RD2(rd2_n), .Busy1(busy1_n), .Busy2(busy2_n), .BusyCnt(cnt_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RFWr = 1'b0; Alloc = 1'b0; Flush = 1'b0;
    A3 = '0; AllocA = '0; WD = '0;
  endtask

  initial begin
    rstn = 1'b0;
    A1 = '0; A2 = '0;
    idle();
    #2;
    check("reset_cnt_b", cnt_b, 0);
    check("reset_cnt_n", cnt_n, 0);

    // Writes, allocs and forwarding are all ignored while in reset.
    RFWr = 1'b1; A3 = 5'd5; WD = 32'h1234; A1 = 5'd5; Alloc = 1'b1; AllocA = 5'd5;
    #1;
    check("reset_rd1_bypass", rd1_b, 0);
    check("reset_busy1", busy1_b, 0);
    step();
    step();
    check("reset_rd1_after_edges", rd1_b, 0);
    check("reset_cnt_after_edges", cnt_b, 0);
    idle();
    #2;
    rstn = 1'b1;
    step();
    check("post_reset_rd1", rd1_b, 0);

    // Basic write then read
    RFWr = 1'b1; A3 = 5'd5; WD = 32'hDEADBEEF;
    step();
    idle(); A1 = 5'd5;
    #1;
    check("r5_rd1_b", rd1_b, 32'hDEADBEEF);
    check("r5_rd1_n", rd1_n, 32'hDEADBEEF);

    // Register 0 ignores writes
    RFWr = 1'b1; A3 = 5'd0; WD = 32'h1234; A2 = 5'd0;
    #1;
    check("r0_rd2_same_cycle", rd2_b, 0);
    check("r0_busy2", busy2_b, 0);
    step();
    idle();
    #1;
    check("r0_rd2_after", rd2_b, 0);

    // Forwarding vs. no forwarding
    RFWr = 1'b1; A3 = 5'd7; WD = 32'h11;
    step();
    RFWr = 1'b1; A3 = 5'd7; WD = 32'h55; A1 = 5'd7;
    #1;
    check("fwd_rd1_bypass", rd1_b, 32'h55);
    check("fwd_rd1_nobypass_old", rd1_n, 32'h11);
    step();
    idle();
    #1;
    check("fwd_rd1_nobypass_new", rd1_n, 32'h55);

    // Alloc then write-back R3
    Alloc = 1'b1; AllocA = 5'd3;
    step();
    idle(); A1 = 5'd3;
    #1;
    check("alloc3_busy1_b", busy1_b, 1);
    check("alloc3_busy1_n", busy1_n, 1);
    check("alloc3_cnt", cnt_b, 1);
    RFWr = 1'b1; A3 = 5'd3; WD = 32'h33;
    #1;
    check("wb3_busy1_bypass", busy1_b, 0);
    check("wb3_busy1_nobypass", busy1_n, 1);
    step();
    idle();
    #1;
    check("wb3_cnt_b", cnt_b, 0);
    check("wb3_cnt_n", cnt_n, 0);
    check("wb3_busy1_after", busy1_n, 0);
    check("wb3_rd1", rd1_n, 32'h33);

    // Same-cycle alloc and write-back to R4: new producer wins
    Alloc = 1'b1; AllocA = 5'd4; RFWr = 1'b1; A3 = 5'd4; WD = 32'h44;
    step();
    idle(); A1 = 5'd4;
    #1;
    check("same4_busy1", busy1_b, 1);
    check("same4_cnt", cnt_b, 1);
    check("same4_rd1", rd1_b, 32'h44);

    Alloc = 1'b1; AllocA = 5'd2;
    step();
    idle();
    check("alloc2_cnt", cnt_b, 2);

    // Distinct alloc R6 and write-back R2: +1-1
    Alloc = 1'b1; AllocA = 5'd6; RFWr = 1'b1; A3 = 5'd2; WD = 32'h22;
    step();
    idle(); A1 = 5'd2; A2 = 5'd6;
    #1;
    check("swap_cnt", cnt_b, 2);
    check("swap_busy1_r2", busy1_b, 0);
    check("swap_busy2_r6", busy2_b, 1);

    // Write-back to non-busy R10 leaves count alone
    RFWr = 1'b1; A3 = 5'd10; WD = 32'hA0;
    step();
    idle(); A1 = 5'd10;
    #1;
    check("wb_nonbusy_cnt", cnt_b, 2);
    check("wb_nonbusy_rd1", rd1_b, 32'hA0);

    // Re-alloc of busy R4 leaves count alone
    Alloc = 1'b1; AllocA = 5'd4;
    step();
    idle();
    check("realloc4_cnt", cnt_b, 2);

    Flush = 1'b1;
    step();
    idle();
    check("flush_cnt", cnt_b, 0);

    // Fill every register
    for (int i = 1; i < 32; i++) begin
      Alloc = 1'b1; AllocA = AW'(i);
      step();
    end
    idle();
    check("full_cnt", cnt_b, 31);
    Alloc = 1'b1; AllocA = 5'd0; A1 = 5'd0;
    step();
    idle();
    check("full_alloc_r0_cnt", cnt_b, 31);
    check("full_r0_busy1", busy1_b, 0);

    // Flush overrides alloc but not the storage write
    Flush = 1'b1; Alloc = 1'b1; AllocA = 5'd9; RFWr = 1'b1; A3 = 5'd12; WD = 32'hC;
    step();
    idle(); A1 = 5'd9; A2 = 5'd12;
    #1;
    check("flush_alloc_cnt", cnt_b, 0);
    check("flush_alloc_busy1_r9", busy1_b, 0);
    check("flush_write_rd2_r12", rd2_n, 32'hC);

    // Asynchronous reset with R8 holding data and pending
    RFWr = 1'b1; A3 = 5'd8; WD = 32'hFF;
    step();
    idle(); Alloc = 1'b1; AllocA = 5'd8;
    step();
    idle(); A1 = 5'd8;
    #1;
    check("pre_rst_rd1_r8", rd1_b, 32'hFF);
    check("pre_rst_cnt", cnt_b, 1);
    check("pre_rst_busy1", busy1_b, 1);
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_rd1", rd1_b, 0);
    check("async_rst_cnt", cnt_b, 0);
    check("async_rst_busy1", busy1_b, 0);
    #2;
    rstn = 1'b1;
    step();
    check("post_rst2_cnt", cnt_b, 0);
    Alloc = 1'b1; AllocA = 5'd3;
    step();
    idle();
    check("post_rst2_alloc_cnt", cnt_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
